// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver feeding a 32-entry first-word-fall-through byte queue.
// One queue slot is always left empty so that full and empty can be told apart from the pointers alone.
module uart_rx (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] baud_div_i,
    input  logic        rx_i,
    input  logic        re_i,
    output logic [7:0]  data_o,
    output logic        full_o,
    output logic        empty_o,
    output logic        frame_err_o,
    output logic        overrun_o
);
    localparam logic [3:0] IDLE = 4'd0, START = 4'd1, DATA_0 = 4'd2, STOP = 4'd10;
    logic        rx_m, rx_s;
    logic [3:0]  state;
    logic [15:0] cnt;
    logic [7:0]  shift;
    logic [7:0]  mem [32];
    logic [4:0]  write_ptr, read_ptr;
    logic        half_hit, bit_hit, push, pop;
    assign half_hit = cnt == (baud_div_i >> 1);
    assign bit_hit  = cnt == baud_div_i;
    assign push     = state == STOP && bit_hit && rx_s && !full_o;
    assign pop      = re_i && !empty_o;
    assign empty_o  = read_ptr == write_ptr;
    assign full_o   = 5'(write_ptr + 5'd1) == read_ptr;
    assign data_o   = mem[read_ptr];
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_m        <= 1'b1;
            rx_s        <= 1'b1;
            state       <= IDLE;
            cnt         <= '0;
            shift       <= '0;
            write_ptr   <= '0;
            read_ptr    <= '0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            rx_m        <= rx_i;
            rx_s        <= rx_m;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
            cnt         <= cnt + 16'd1;
            if (push) write_ptr <= write_ptr + 5'd1;
            if (pop) read_ptr <= read_ptr + 5'd1;
            case (state)
                IDLE: if (!rx_s) begin
                    state <= START;
                    cnt   <= '0;
                end
                START: if (half_hit) begin
                    state <= rx_s ? IDLE : DATA_0;
                    cnt   <= '0;
                end
                // Leaving at mid-stop-bit lets a back-to-back start edge be caught.
                STOP: if (bit_hit) begin
                    state       <= IDLE;
                    cnt         <= '0;
                    frame_err_o <= !rx_s;
                    overrun_o   <= rx_s && full_o;
                end
                default: if (bit_hit) begin
                    shift[3'(state - DATA_0)] <= rx_s;
                    state <= state + 4'd1;
                    cnt   <= '0;
                end
            endcase
        end
    end
    always_ff @(posedge clk_i) begin
        if (push) mem[write_ptr] <= shift;
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and random 8N1 frames checked against a frame-level queue model.
module tb_uart_rx;
    logic        clk_i = 1'b0, rst_i = 1'b1, rx_i = 1'b1, re_i = 1'b0;
    logic [15:0] baud_div_i = 16'd9;
    logic [7:0]  data_o;
    logic        full_o, empty_o, frame_err_o, overrun_o;
    int          cyc = 0, fe_cnt = 0, ov_cnt = 0, exp_fe = 0, exp_ov = 0, n_vec = 0, n_err = 0;
    logic [7:0]  exp_q[$];
    logic        fe_bit, ov_bit;

    uart_rx dut (
        .clk_i(clk_i), .rst_i(rst_i), .baud_div_i(baud_div_i), .rx_i(rx_i), .re_i(re_i),
        .data_o(data_o), .full_o(full_o), .empty_o(empty_o),
        .frame_err_o(frame_err_o), .overrun_o(overrun_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;
    always @(negedge clk_i) begin
        if (frame_err_o) fe_cnt++;
        if (overrun_o) ov_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int bit_time();
        return int'(baud_div_i) + 1;
    endfunction

    // A frame's fate depends only on its stop bit and the queue occupancy when it ends.
    task automatic model_frame(input logic [7:0] b, input logic stop, input logic pop,
                               output logic fe, output logic ov);
        fe = !stop;
        ov = stop && exp_q.size() == 31;
        if (pop) void'(exp_q.pop_front());
        if (stop && !ov) exp_q.push_back(b);
        exp_fe += int'(fe);
        exp_ov += int'(ov);
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_i = bits[i];
            repeat (bit_time()) @(negedge clk_i);
        end
        rx_i = 1'b1;
    endtask

    task automatic gap();
        repeat (2 * bit_time() + 4) @(negedge clk_i);
    endtask

    task automatic send_plain(input logic [7:0] b, input logic stop);
        logic fe, ov;
        model_frame(b, stop, 1'b0, fe, ov);
        drive_frame(b, stop);
        gap();
    endtask

    // Stop bit is sampled h + 9 bit times after START, which starts 3 cycles after the falling edge.
    task automatic send_timed(input logic [7:0] b, input logic stop, input logic pop_at_push);
        int   p;
        logic pre_empty, fe, ov, post_empty;
        logic [7:0] head;
        pre_empty = exp_q.size() == 0;
        p = cyc + 1 + (int'(baud_div_i) >> 1) + 9 * bit_time() + 3;
        model_frame(b, stop, pop_at_push, fe, ov);
        post_empty = exp_q.size() == 0;
        head = post_empty ? 8'h00 : exp_q[0];
        fork
            drive_frame(b, stop);
            begin
                while (cyc < p - 1) @(negedge clk_i);
                check("empty_before_stop", empty_o, pre_empty);
                check("flags_before_stop", {frame_err_o, overrun_o}, 2'b00);
                re_i = pop_at_push;
                @(negedge clk_i);
                re_i = 1'b0;
                check("empty_after_stop", empty_o, post_empty);
                check("frame_err_pulse", frame_err_o, fe);
                check("overrun_pulse", overrun_o, ov);
                if (!post_empty) check("head_after_stop", data_o, head);
                @(negedge clk_i);
                check("flags_one_cycle", {frame_err_o, overrun_o}, 2'b00);
            end
        join
        gap();
    endtask

    task automatic pop_check();
        check("pop_data", data_o, exp_q[0]);
        re_i = 1'b1;
        @(negedge clk_i);
        re_i = 1'b0;
        void'(exp_q.pop_front());
        check("pop_empty", empty_o, exp_q.size() == 0);
        check("pop_full", full_o, exp_q.size() == 31);
    endtask

    task automatic check_state();
        check("empty", empty_o, exp_q.size() == 0);
        check("full", full_o, exp_q.size() == 31);
        check("frame_err_count", fe_cnt, exp_fe);
        check("overrun_count", ov_cnt, exp_ov);
    endtask

    initial begin
        logic [7:0] b;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        check("reset_empty", empty_o, 1'b1);
        check("reset_full", full_o, 1'b0);
        check("reset_frame_err", frame_err_o, 1'b0);
        check("reset_overrun", overrun_o, 1'b0);
        repeat (3) @(negedge clk_i);

        send_timed(8'hA5, 1'b1, 1'b0);
        pop_check();

        drive_frame(8'h00, 1'b1);
        drive_frame(8'hFF, 1'b1);
        drive_frame(8'h3C, 1'b1);
        model_frame(8'h00, 1'b1, 1'b0, fe_bit, ov_bit);
        model_frame(8'hFF, 1'b1, 1'b0, fe_bit, ov_bit);
        model_frame(8'h3C, 1'b1, 1'b0, fe_bit, ov_bit);
        gap();
        check_state();
        repeat (3) pop_check();

        rx_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rx_i = 1'b1;
        repeat (30) @(negedge clk_i);
        check_state();

        send_timed(8'h96, 1'b0, 1'b0);
        check_state();

        send_plain(8'h11, 1'b1);
        send_timed(8'h22, 1'b1, 1'b1);
        check_state();
        pop_check();

        baud_div_i = 16'd3;
        repeat (4) @(negedge clk_i);
        for (int i = 0; i < 31; i++) send_plain(8'($urandom), 1'b1);
        check_state();
        send_timed(8'hEE, 1'b1, 1'b0);
        check_state();
        while (exp_q.size() > 0) pop_check();
        check_state();

        baud_div_i = 16'd9;
        repeat (4) @(negedge clk_i);
        send_plain(8'h77, 1'b1);
        b = 8'hC3;
        rx_i = 1'b0;
        repeat (bit_time()) @(negedge clk_i);
        for (int i = 0; i < 4; i++) begin
            rx_i = b[i];
            repeat (bit_time()) @(negedge clk_i);
        end
        rx_i = b[4];
        repeat (bit_time() / 2) @(negedge clk_i);
        rst_i = 1'b1;
        rx_i = 1'b1;
        @(negedge clk_i);
        check("midframe_reset_empty", empty_o, 1'b1);
        check("midframe_reset_full", full_o, 1'b0);
        check("midframe_reset_flags", {frame_err_o, overrun_o}, 2'b00);
        rst_i = 1'b0;
        exp_q.delete();
        repeat (4) @(negedge clk_i);
        send_timed(8'h5A, 1'b1, 1'b0);
        check_state();
        pop_check();

        for (int i = 0; i < 30; i++) begin
            baud_div_i = 16'($urandom_range(3, 12));
            repeat (2) @(negedge clk_i);
            send_timed(8'($urandom), $urandom_range(0, 7) != 0,
                       exp_q.size() > 0 && $urandom_range(0, 3) == 0);
            check_state();
            repeat ($urandom_range(0, 2)) if (exp_q.size() > 0) pop_check();
        end
        while (exp_q.size() > 0) pop_check();
        check_state();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

Receive half of the UART peripheral: deserialises 8N1 frames (1 start bit, 8 data bits LSB first, no parity, 1 stop bit) from the `rx_i` pin into a 32-entry circular byte queue, which the bus side drains. It pairs with `uart_tx` inside the UART peripheral. It shares the same `baud_div_i` register, so both directions run at one baud rate.

## Interface
Parameters: none (queue depth fixed at 32 entries, 5-bit pointers).

- `clk_i` in 1: system clock; the only clock.
- `rst_i` in 1: reset; synchronous, active-high.
- `baud_div_i` in 16: bit period is `baud_div_i`+1 clk_i cycles. Static while a frame is in flight. Minimum legal value is 3.
- `rx_i` in 1: serial input, asynchronous. Idle level is high.
- `re_i` in 1: pop the head byte. Ignored when `empty_o`=1.
- `data_o` out 8: head of the queue, first-word-fall-through. Valid only while `empty_o`=0.
- `full_o` out 1: queue holds 31 bytes (one slot is kept unused).
- `empty_o` out 1: queue holds no bytes.
- `frame_err_o` out 1: one-cycle pulse when a stop bit is sampled low.
- `overrun_o` out 1: one-cycle pulse when a good frame is dropped because the queue is full.

## Operation
- Synchroniser: `rx_i` passes through 2 flops, giving `rx_s`. All decisions use `rx_s` only. Both flops reset to 1.
- Counter: 16-bit `cnt`, cleared on every state change.
- Half-bit threshold: `h` = `baud_div_i`>>1.
- States: IDLE, START, DATA_0..DATA_7, STOP.
  - IDLE: if `rx_s`=0, go to START with `cnt`=0.
  - START: when `cnt`==`h`, go to DATA_0 if `rx_s`=0. If `rx_s`=1, treat it as a glitch and return to IDLE with no flag.
  - DATA_n: when `cnt`==`baud_div_i`, write `rx_s` into shift bit n (bit 0 received first), then go to the next state.
  - STOP: when `cnt`==`baud_div_i`, take the action below, then return to IDLE in every case.
- STOP sample results:
  - `rx_s`=1 and not full: push the byte.
  - `rx_s`=1 and full: drop the byte and pulse `overrun_o`.
  - `rx_s`=0: drop the byte and pulse `frame_err_o`.
- Returning to IDLE at mid-stop-bit allows a back-to-back start bit to be detected.
- Break condition (`rx_i` held low): produces one frame_err per 10-bit time. No lockup.
- Queue pointers:
  - `write_ptr` and `read_ptr` are 5-bit and wrap modulo 32.
  - `empty_o` = (`read_ptr`==`write_ptr`).
  - `full_o` = (`write_ptr`+1 == `read_ptr`), computed in 5-bit arithmetic.
  - A push and a pop in the same cycle are both performed.
  - A pop while empty has no effect. A push is never attempted while full.
- Queue storage is not reset. Pointers, state, `cnt` and the shift register are reset.

## Timing
- Reset values:
  - `empty_o`=1, `full_o`=0, `frame_err_o`=0, `overrun_o`=0.
  - `data_o` is undefined.
  - State is IDLE.
- Reset asserted mid-frame aborts the frame. No push and no flag result from it.
- `rx_i` falling edge to START entry: 3 cycles (2 synchroniser cycles + 1 IDLE decision cycle).
- With START entered at t0:
  - Start-bit check occurs at t0+`h`.
  - Data bit n is sampled at t0+`h`+(n+1)(`baud_div_i`+1).
  - Stop bit is sampled at t0+`h`+9(`baud_div_i`+1).
- Push: `empty_o` falls and `data_o` is valid on the cycle after the stop sample.
- `frame_err_o` / `overrun_o` are asserted for exactly that same one cycle.
- Pop: `re_i` high at cycle t advances `read_ptr` at t+1. `data_o` shows the next byte at t+1, and `empty_o`/`full_o` update at t+1.

## Test plan
- Byte, 10-cycle bit period: `baud_div_i`=9, send 0xA5 as 8N1 → `empty_o` falls 1 cycle after the stop sample; `data_o`=0xA5; `re_i` pulse → `empty_o`=1 next cycle.
- Back-to-back: send 0x00, 0xFF, 0x3C with no idle gap → 3 bytes queued in order; pop returns 0x00, 0xFF, 0x3C; no flags.
- Glitch and framing:
  - A 3-cycle low glitch on idle `rx_i` (`baud_div_i`=9) → no push, no flag.
  - A frame with stop bit = 0 → one `frame_err_o` pulse, queue unchanged.
- Full and overrun: send 31 bytes without popping → `full_o`=1; a 32nd good byte → one `overrun_o` pulse, count stays 31; pop all 31 → values match and pointers wrap cleanly past 31→0.
- Simultaneous push/pop: with 1 byte queued, pop in exactly the cycle the next byte is pushed → count stays 1, `empty_o` stays 0, `data_o` = new byte.
- Reset mid-frame: assert `rst_i` during DATA_4 → next cycle `empty_o`=1, all flags 0; the following clean frame 0x5A is received correctly.
